// File: rtl/regfile_dbg_pkg.sv
// rtl/regfile_dbg_pkg.sv - shared widths and state encoding for the register-file dumper
package regfile_dbg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_FIN
    } dump_state_t;

endpackage

// File: rtl/regfile_dumper.sv
// rtl/regfile_dumper.sv - walks a register-file index range and streams each value as a beat
module regfile_dumper
    import regfile_dbg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [REG_ADDR_W-1:0] first_addr,
    input  logic [REG_ADDR_W-1:0] last_addr,
    input  logic                  abort,
    output logic [REG_ADDR_W-1:0] ra,
    input  logic [REG_DATA_W-1:0] rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_addr,
    output logic [REG_DATA_W-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    dump_state_t           state;
    logic [REG_ADDR_W-1:0] ptr;
    logic [REG_ADDR_W-1:0] last;
    logic                  hs;

    assign ra   = ptr;
    assign hs   = out_valid & out_ready;
    assign busy = (state == ST_LOAD) || (state == ST_SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            last      <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        last <= last_addr;
                        if (first_addr <= last_addr) begin
                            ptr   <= first_addr;
                            state <= ST_LOAD;
                        end else begin
                            // Inverted range: no beats, just the completion pulse.
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_LOAD, ST_SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (state == ST_LOAD || (hs && !out_last)) begin
                        // rd is sampled here, so a same-edge register-file write is not seen.
                        out_data  <= rd;
                        out_addr  <= ptr;
                        out_last  <= (ptr == last);
                        ptr       <= ptr + 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_SEND;
                    end else if (hs) begin
                        out_valid <= 1'b0;
                        state     <= ST_FIN;
                        done      <= 1'b1;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
